// File: rtl/sram_access_ctrl_if.sv
// sram_access_ctrl_if
// Request/response handshake between the user side and sram_access_ctrl.
//   req_valid / req_ready : request handshake (accept on both high at a rising edge)
//   req_we                : 1 = write, 0 = read
//   req_addr              : [7:4] row, [3:0] column word
//   req_wdata             : write data
//   rsp_valid             : one-cycle completion pulse
//   rsp_rdata             : read data, held until the next read response
// master = requester side, slave = controller side.
interface sram_access_ctrl_if #(
  parameter int WORD_SIZE = 4
);
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_we;
  logic [7:0]           req_addr;
  logic [WORD_SIZE-1:0] req_wdata;
  logic                 rsp_valid;
  logic [WORD_SIZE-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/sram_access_ctrl.sv
// sram_access_ctrl
// Sequences one SRAM access at a time: precharge, wordline (write drive or
// sense), one recover cycle, then back to idle.
// Ports:
//   clk, rst_n     : clock, synchronous active-low reset
//   bus (slave)    : request/response handshake, see sram_access_ctrl_if
//   precharge_en   : bitline precharge
//   wordline       : one-hot row enable
//   col_select     : one-hot column word select
//   write_en       : write driver enable
//   drive_data     : write driver data (0 when write_en is low)
//   sense_en       : sense amp enable
//   sense_data     : sense amp output for the selected column
//   verify_err     : only with SRAM_ACCESS_CTRL_VERIFY_EN; read-back mismatch,
//                    valid with rsp_valid
// Optional feature macro: SRAM_ACCESS_CTRL_VERIFY_EN (adds write read-back).
//
// state   | meaning
// IDLE    | req_ready high, waiting for a request
// PRECH   | precharge_en high for PRECH_CYCLES clocks
// ACCESS  | wordline high for ACCESS_CYCLES clocks, write drive or sense
// RECOVER | array controls off, rsp_valid pulse
module sram_access_ctrl #(
  parameter int WORD_SIZE     = 4,
  parameter int NUM_WORDS     = 16,
  parameter int NUM_ROWS      = 16,
  parameter int PRECH_CYCLES  = 2,
  parameter int ACCESS_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sram_access_ctrl_if.slave    bus,
  output logic                 precharge_en,
  output logic [NUM_ROWS-1:0]  wordline,
  output logic [NUM_WORDS-1:0] col_select,
  output logic                 write_en,
  output logic [WORD_SIZE-1:0] drive_data,
  output logic                 sense_en,
  input  logic [WORD_SIZE-1:0] sense_data
`ifdef SRAM_ACCESS_CTRL_VERIFY_EN
  ,
  output logic                 verify_err
`endif
);

  typedef enum logic [1:0] {IDLE, PRECH, ACCESS, RECOVER} state_t;

  localparam logic [3:0] PRECH_LOAD  = 4'(PRECH_CYCLES - 1);
  localparam logic [3:0] ACCESS_LOAD = 4'(ACCESS_CYCLES - 1);
`ifdef SRAM_ACCESS_CTRL_VERIFY_EN
  localparam bit VERIFY_EN = 1'b1;
`else
  localparam bit VERIFY_EN = 1'b0;
`endif

  state_t               state, state_nxt;
  logic [3:0]           cnt, cnt_nxt;
  logic                 verify_q, verify_nxt;
  logic                 we_q;
  logic [7:0]           addr_q;
  logic [WORD_SIZE-1:0] wdata_q;
  logic [WORD_SIZE-1:0] rdata_q;
  logic                 accept;
  logic                 last_cycle;
  logic                 read_phase;
  logic [NUM_ROWS-1:0]  row_onehot;
  logic [NUM_WORDS-1:0] col_onehot;

  assign accept     = (state == IDLE) && bus.req_valid;
  assign last_cycle = (cnt == 4'd0);
  // A verify pass re-reads the just-written word, so it runs as a read.
  assign read_phase = !we_q || verify_q;
  assign row_onehot = NUM_ROWS'(1) << addr_q[7:4];
  assign col_onehot = NUM_WORDS'(1) << addr_q[3:0];
  assign bus.rsp_rdata = rdata_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      verify_q <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= 8'd0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      verify_q <= verify_nxt;
      if (accept) begin
        we_q    <= bus.req_we;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
      end
      // Verify read-back must not disturb the held read data.
      if (sense_en && !verify_q)
        rdata_q <= sense_data;
    end
  end

`ifdef SRAM_ACCESS_CTRL_VERIFY_EN
  always_ff @(posedge clk) begin
    if (!rst_n)
      verify_err <= 1'b0;
    else if (accept)
      verify_err <= 1'b0;
    else if (sense_en && verify_q)
      verify_err <= (sense_data != wdata_q);
  end
`endif

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    verify_nxt    = verify_q;
    precharge_en  = 1'b0;
    wordline      = '0;
    col_select    = '0;
    write_en      = 1'b0;
    drive_data    = '0;
    sense_en      = 1'b0;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          state_nxt  = PRECH;
          cnt_nxt    = PRECH_LOAD;
          verify_nxt = 1'b0;
        end
      end
      PRECH: begin
        precharge_en = 1'b1;
        col_select   = col_onehot;
        if (last_cycle) begin
          state_nxt = ACCESS;
          cnt_nxt   = ACCESS_LOAD;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      ACCESS: begin
        wordline   = row_onehot;
        col_select = col_onehot;
        write_en   = !read_phase;
        drive_data = read_phase ? '0 : wdata_q;
        sense_en   = read_phase && last_cycle;
        if (last_cycle) begin
          if (VERIFY_EN && !read_phase) begin
            state_nxt  = PRECH;
            cnt_nxt    = PRECH_LOAD;
            verify_nxt = 1'b1;
          end else begin
            state_nxt = RECOVER;
          end
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      RECOVER: begin
        bus.rsp_valid = 1'b1;
        state_nxt     = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sram_access_ctrl.sv
// tb_sram_access_ctrl
// Two controller instances: dut0 at default timing (2/2), dut1 at the
// 1/15 corner. A transaction-level model predicts every output from the
// number of cycles elapsed since the request was accepted.
module tb_sram_access_ctrl;

  localparam int P0 = 2;
  localparam int A0 = 2;
  localparam int P1 = 1;
  localparam int A1 = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n0, rst_n1;
  sram_access_ctrl_if #(.WORD_SIZE(4)) bus0 ();
  sram_access_ctrl_if #(.WORD_SIZE(4)) bus1 ();

  logic        pre0, we0, se0, pre1, we1, se1;
  logic [15:0] wl0, col0, wl1, col1;
  logic [3:0]  dd0, sd0, dd1, sd1;
`ifdef SRAM_ACCESS_CTRL_VERIFY_EN
  logic        ve0, ve1;
`endif

  sram_access_ctrl #(.PRECH_CYCLES(P0), .ACCESS_CYCLES(A0)) dut0 (
    .clk(clk), .rst_n(rst_n0), .bus(bus0),
    .precharge_en(pre0), .wordline(wl0), .col_select(col0),
    .write_en(we0), .drive_data(dd0), .sense_en(se0), .sense_data(sd0)
`ifdef SRAM_ACCESS_CTRL_VERIFY_EN
    , .verify_err(ve0)
`endif
  );

  sram_access_ctrl #(.PRECH_CYCLES(P1), .ACCESS_CYCLES(A1)) dut1 (
    .clk(clk), .rst_n(rst_n1), .bus(bus1),
    .precharge_en(pre1), .wordline(wl1), .col_select(col1),
    .write_en(we1), .drive_data(dd1), .sense_en(se1), .sense_data(sd1)
`ifdef SRAM_ACCESS_CTRL_VERIFY_EN
    , .verify_err(ve1)
`endif
  );

  typedef struct {
    logic       busy;
    int         k;       // cycle number within the current access, 1-based
    logic       we;
    logic [7:0] addr;
    logic [3:0] wdata;
    logic [3:0] rdata;
  } model_t;

  typedef struct {
    logic        we;
    logic [7:0]  addr;
    logic [3:0]  wdata;
    logic [3:0]  sense;
    logic [15:0] wl;
    logic [15:0] col;
    logic [3:0]  rd;
  } vec_t;

  model_t m0, m1;
  vec_t   vecs [6];
  int     n_chk = 0;
  int     n_fail = 0;
  int     gap, n_low;
  logic   rv_seen;
  logic [63:0] e;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Predicts the state after the coming rising edge from the inputs now applied.
  task automatic model_step(inout model_t m, input int p, input int a, input logic rst,
                            input logic valid, input logic we, input logic [7:0] addr,
                            input logic [3:0] wdata, input logic [3:0] sense);
    if (!rst) begin
      m.busy = 1'b0; m.k = 0; m.rdata = 4'h0;
    end else if (m.busy) begin
      if (m.k == p + a && !m.we) m.rdata = sense;
      if (m.k == p + a + 1) m.busy = 1'b0;
      else m.k++;
    end else if (valid) begin
      m.busy = 1'b1; m.k = 1; m.we = we; m.addr = addr; m.wdata = wdata;
    end
  endtask

  task automatic model_check(input string nm, input model_t m, input int p, input int a,
                             input logic ready, input logic pre, input logic [15:0] wl,
                             input logic [15:0] col, input logic we, input logic [3:0] dd,
                             input logic se, input logic rv, input logic [3:0] rd);
    logic acc, x_pre, x_we, x_se, x_rv;
    logic [15:0] x_wl, x_col;
    logic [3:0]  x_dd;
    acc   = m.busy && m.k > p && m.k <= p + a;
    x_pre = m.busy && m.k <= p;
    x_wl  = acc ? (16'd1 << m.addr[7:4]) : 16'd0;
    x_col = (m.busy && m.k <= p + a) ? (16'd1 << m.addr[3:0]) : 16'd0;
    x_we  = acc && m.we;
    x_dd  = x_we ? m.wdata : 4'h0;
    x_se  = acc && !m.we && m.k == p + a;
    x_rv  = m.busy && m.k == p + a + 1;
    check({nm, "_outputs"}, {ready, pre, wl, col, we, dd, se, rv, rd},
          {!m.busy, x_pre, x_wl, x_col, x_we, x_dd, x_se, x_rv, m.rdata});
    check({nm, "_invariants"},
          {!(pre && |wl), !(we && se), $onehot0(wl), $onehot0(col), (we || dd == 4'h0)},
          5'b11111);
  endtask

  task automatic tick();
    model_step(m0, P0, A0, rst_n0, bus0.req_valid, bus0.req_we, bus0.req_addr, bus0.req_wdata, sd0);
    model_step(m1, P1, A1, rst_n1, bus1.req_valid, bus1.req_we, bus1.req_addr, bus1.req_wdata, sd1);
    @(posedge clk);
    @(negedge clk);
    model_check("dut0", m0, P0, A0, bus0.req_ready, pre0, wl0, col0, we0, dd0, se0,
                bus0.rsp_valid, bus0.rsp_rdata);
    model_check("dut1", m1, P1, A1, bus1.req_ready, pre1, wl1, col1, we1, dd1, se1,
                bus1.rsp_valid, bus1.rsp_rdata);
  endtask

  task automatic wait_idle0();
    int n = 0;
    while (!bus0.req_ready && n < 40) begin
      tick();
      n++;
    end
    if (!bus0.req_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL idle_timeout: req_ready still %b after %0d cycles", bus0.req_ready, n);
    end
  endtask

  initial begin
    vecs[0] = '{1'b1, 8'h3A, 4'h9, 4'h0, 16'h0008, 16'h0400, 4'h0};
    vecs[1] = '{1'b0, 8'hF0, 4'h0, 4'h6, 16'h8000, 16'h0001, 4'h6};
    vecs[2] = '{1'b1, 8'h00, 4'hF, 4'h1, 16'h0001, 16'h0001, 4'h6};
    vecs[3] = '{1'b0, 8'h5C, 4'h0, 4'hA, 16'h0020, 16'h1000, 4'hA};
    vecs[4] = '{1'b1, 8'hFF, 4'h0, 4'h5, 16'h8000, 16'h8000, 4'hA};
    vecs[5] = '{1'b0, 8'h81, 4'h0, 4'h3, 16'h0100, 16'h0002, 4'h3};

    // Reset held 3 cycles with a request pending.
    rst_n0 = 1'b0; rst_n1 = 1'b0;
    bus0.req_valid = 1'b1; bus0.req_we = 1'b1; bus0.req_addr = 8'h3A; bus0.req_wdata = 4'h9;
    bus1.req_valid = 1'b0; bus1.req_we = 1'b0; bus1.req_addr = 8'h00; bus1.req_wdata = 4'h0;
    sd0 = 4'h0; sd1 = 4'h0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("rst_hold%0d", i), {pre0, wl0, col0, we0, dd0, se0, bus0.rsp_valid}, 0);
    end
    bus0.req_valid = 1'b0;
    rst_n0 = 1'b1; rst_n1 = 1'b1;
    tick();
    check("rst_release", {bus0.req_ready, bus0.rsp_valid, bus0.rsp_rdata}, {1'b1, 1'b0, 4'h0});

    // Directed vectors; request inputs are scrambled while busy and must be ignored.
    for (int i = 0; i < 6; i++) begin
      wait_idle0();
      bus0.req_valid = 1'b1; bus0.req_we = vecs[i].we;
      bus0.req_addr = vecs[i].addr; bus0.req_wdata = vecs[i].wdata;
      sd0 = vecs[i].sense;
      tick();
      bus0.req_we = ~vecs[i].we; bus0.req_addr = ~vecs[i].addr; bus0.req_wdata = ~vecs[i].wdata;
      for (int k = 1; k <= 5; k++) begin
        e = {k <= 2,
             (k == 3 || k == 4) ? vecs[i].wl : 16'h0,
             k <= 4 ? vecs[i].col : 16'h0,
             (k == 3 || k == 4) && vecs[i].we,
             ((k == 3 || k == 4) && vecs[i].we) ? vecs[i].wdata : 4'h0,
             !vecs[i].we && k == 4,
             k == 5,
             1'b0};
        check($sformatf("vec%0d_cyc%0d", i, k),
              {pre0, wl0, col0, we0, dd0, se0, bus0.rsp_valid, bus0.req_ready}, e);
        if (k == 4) bus0.req_valid = 1'b0;
        if (k == 5) check($sformatf("vec%0d_rdata", i), bus0.rsp_rdata, vecs[i].rd);
        if (k < 5) tick();
      end
      tick();
      check($sformatf("vec%0d_idle", i), {bus0.req_ready, bus0.rsp_valid}, 2'b10);
    end

    // Back-to-back writes with req_valid held.
    wait_idle0();
    bus0.req_valid = 1'b1; bus0.req_we = 1'b1; bus0.req_addr = 8'h11; bus0.req_wdata = 4'h5;
    tick();
    bus0.req_addr = 8'h22; bus0.req_wdata = 4'hC;
    gap = 0; n_low = 0;
    for (int c = 1; c <= 12 && gap == 0; c++) begin
      if (bus0.req_ready) gap = c;
      else n_low++;
      tick();
    end
    check("b2b_gap", gap, 6);
    check("b2b_ready_low", n_low, 5);
    check("b2b_second_busy", {bus0.req_ready, pre0}, 2'b01);
    bus0.req_valid = 1'b0;
    wait_idle0();

    // Reset in the first ACCESS cycle of a write.
    bus0.req_valid = 1'b1; bus0.req_we = 1'b1; bus0.req_addr = 8'h3A; bus0.req_wdata = 4'h9;
    tick();
    bus0.req_valid = 1'b0;
    tick();
    tick();
    check("mid_access", {we0, wl0, dd0}, {1'b1, 16'h0008, 4'h9});
    rst_n0 = 1'b0;
    tick();
    check("mid_abort", {we0, wl0, se0, pre0, bus0.rsp_valid}, 0);
    rst_n0 = 1'b1;
    rv_seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      rv_seen |= bus0.rsp_valid;
    end
    check("mid_no_rsp", {rv_seen, bus0.req_ready}, 2'b01);

    // Random traffic on both instances, with occasional resets.
    for (int i = 0; i < 4000; i++) begin
      bus0.req_valid = 1'($urandom_range(0, 1));
      bus0.req_we    = 1'($urandom_range(0, 1));
      bus0.req_addr  = 8'($urandom_range(0, 255));
      bus0.req_wdata = 4'($urandom_range(0, 15));
      sd0            = 4'($urandom_range(0, 15));
      rst_n0         = ($urandom_range(0, 299) != 0);
      bus1.req_valid = 1'($urandom_range(0, 1));
      bus1.req_we    = 1'($urandom_range(0, 1));
      bus1.req_addr  = 8'($urandom_range(0, 255));
      bus1.req_wdata = 4'($urandom_range(0, 15));
      sd1            = 4'($urandom_range(0, 15));
      rst_n1         = ($urandom_range(0, 299) != 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_access_ctrl.md
Name: sram_access_ctrl

Overview:
Sequencing controller for one 4-bit-word SRAM macro built from the bitline write driver, row decoder wordlines, precharge and sense amplifiers. Accepts one read or write request at a time over a valid/ready handshake. Runs precharge, wordline, write-drive or sense phases with programmable cycle counts. Returns read data with a one-cycle response pulse. Sits between the top-level user interface and the analog-style array datapath.

Parameters:
WORD_SIZE, 4, bits per word; width of wdata, rdata and drive_data.
NUM_WORDS, 16, words per row; width of the one-hot col_select.
NUM_ROWS, 16, rows; width of the one-hot wordline.
PRECH_CYCLES, 2, clocks precharge_en is held high; legal range 1..15.
ACCESS_CYCLES, 2, clocks the wordline is high while driving or sensing; legal range 1..15.

Ports:
clk  in  1  system clock; all logic is on the rising edge.
rst_n  in  1  synchronous active-low reset.
req_valid  in  1  request present.
req_ready  out  1  controller can accept a request (IDLE only).
req_we  in  1  1 = write, 0 = read.
req_addr  in  8  [7:4] row, [3:0] column word.
req_wdata  in  WORD_SIZE  write data.
rsp_valid  out  1  one-cycle pulse when the access completes (read or write).
rsp_rdata  out  WORD_SIZE  read data; held until the next read response.
precharge_en  out  1  bitline precharge.
wordline  out  NUM_ROWS  one-hot row enable.
col_select  out  NUM_WORDS  one-hot column word select to the write driver and sense mux.
write_en  out  1  write driver enable.
drive_data  out  WORD_SIZE  data to the write driver.
sense_en  out  1  sense amp enable.
sense_data  in  WORD_SIZE  sense amp output for the selected column.

Behaviour:
- Reset (rst_n low at posedge): state = IDLE. All outputs 0, except req_ready = 1 after reset. Latched address and data cleared. Reset during any phase aborts immediately: wordline, write_en and sense_en are all 0 on the next cycle, and no rsp_valid is issued.
- Handshake: accept when req_valid && req_ready at a posedge. Capture we, addr and wdata into registers. req_ready falls the next cycle and stays 0 until back in IDLE. Requests are never queued.
- States: IDLE -> PRECH -> ACCESS -> RECOVER -> IDLE.
- PRECH: precharge_en = 1 for exactly PRECH_CYCLES clocks. wordline, write_en and sense_en are 0. col_select = decoded column, valid from the first PRECH cycle.
- ACCESS: wordline[row] = 1 for ACCESS_CYCLES clocks; precharge_en = 0.
  - Write: write_en = 1 and drive_data = latched wdata for all ACCESS cycles.
  - Read: sense_en = 1 for the final ACCESS cycle only. sense_data is sampled into rsp_rdata at the end of that cycle.
- RECOVER: one cycle; wordline, write_en and sense_en are all 0. rsp_valid = 1 in this cycle; rsp_rdata is valid for reads. On a write, rsp_rdata is unchanged.
- Return to IDLE: req_ready = 1 the cycle after RECOVER.
- Latency from accept edge to rsp_valid high is PRECH_CYCLES + ACCESS_CYCLES + 1 cycles. At defaults this is 5 cycles; one access completes every 6 cycles.
- Phase counter: 4 bits. It loads N-1 on phase entry and advances at 0. Values 1 and 15 must work without wrap errors.
- Invariants (never violated):
  - precharge_en and wordline are never both active.
  - write_en and sense_en are never both 1.
  - wordline and col_select are 0 or one-hot, never multi-hot.
  - drive_data = 0 whenever write_en = 0.
- Inputs arriving outside IDLE (req_valid, req_we, req_addr, req_wdata) are ignored. The latched values are used.

Optional Feature:
SRAM_ACCESS_CTRL_VERIFY_EN.
- When defined, every write is followed automatically by a read-back: PRECH -> ACCESS(read) -> RECOVER at the same address before the response.
- Added output: verify_err (1 bit). It is valid with rsp_valid and is 1 if the sensed data differs from wdata.
- Write latency becomes 2*(PRECH_CYCLES + ACCESS_CYCLES) + 1 cycles. Read latency is unchanged.
- Undefined: the verify_err port is absent and writes behave as described above.

Test Plan:
- Reset: hold rst_n low for 3 cycles while req_valid = 1 -> all array controls are 0, req_ready = 1 after release, and no rsp_valid occurs.
- Write at addr 0x3A, wdata 0x9 (defaults) -> the following, with rsp_valid 5 cycles after accept:
  - precharge_en high 2 cycles;
  - then wordline = 0x0008, col_select = 0x0400, write_en = 1 and drive_data = 0x9 for 2 cycles.
- Read at addr 0xF0 with sense_data = 0x6 -> wordline = 0x8000, col_select = 0x0001, sense_en high only in the second ACCESS cycle, rsp_rdata = 0x6 alongside rsp_valid.
- Back-to-back: hold req_valid for two writes -> the second is accepted exactly 6 cycles after the first, and req_ready is 0 in between.
- Reset mid-ACCESS of a write -> write_en and wordline are 0 the next cycle, and no rsp_valid is issued.
- Parameter corners: PRECH_CYCLES = 1, ACCESS_CYCLES = 15 -> phase lengths are exact, and the invariants hold throughout (checked by assertions on every cycle).
